serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller. Shares one full_adder instance (a,b,c -> sum,carry)

---
 rtl/serial_add_ctrl.sv | 111 +++++++++++
 tb/tb_serial_add_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder walks the operands LSB first,
// sequenced by a three-state IDLE/RUN/DONE controller.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nxt;
   logic             c_reg;
   logic [CW-1:0]    cnt;
   logic             fa_sum, fa_carry;
   logic             load, step, last;

   full_adder u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .c     (c_reg),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // New sum bits enter at the MSB so the result lands aligned after WIDTH steps.
   generate
      if (WIDTH == 1) begin : g_w1
         assign s_nxt = fa_sum;
      end else begin : g_wn
         assign s_nxt = {fa_sum, s_sr[WIDTH-1:1]};
      end
   endgenerate

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: if (start) begin
            load      = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            step = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         s_sr    <= '0;
         c_reg   <= 1'b0;
         cnt     <= '0;
         sum_out <= '0;
         cout    <= 1'b0;
      end else if (load) begin
         a_sr  <= a_in;
         b_sr  <= b_in;
         c_reg <= cin;
         cnt   <= '0;
      end else if (step) begin
         s_sr  <= s_nxt;
         c_reg <= fa_carry;
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         cnt   <= cnt + 1'b1;
         if (last) begin
            sum_out <= s_nxt;
            cout    <= fa_carry;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=1.

module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start1 = 1'b0, cin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Call at #1 after an edge with dut8 idle.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
      logic [8:0] exp;
      logic [7:0] ps;
      logic       pc, hold_ok;
      int         n;
      exp = {1'b0, a} + {1'b0, b} + {8'b0, c};
      ps = sum8; pc = cout8; hold_ok = 1'b1;
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
      n = 1;
      while (!done8 && n < 40) begin
         if (sum8 !== ps || cout8 !== pc) hold_ok = 1'b0;
         tick();
         n++;
      end
      check({tag, " latency"}, n, 9);
      check({tag, " hold"}, hold_ok, 1'b1);
      check({tag, " result"}, {cout8, sum8}, exp);
      check({tag, " busy in done"}, busy8, 1'b1);
      tick();
      check({tag, " done pulse"}, {busy8, done8}, 2'b00);
   endtask

   task automatic op1(input logic a, input logic b, input logic c, input string tag);
      logic [1:0] exp;
      int         n;
      exp = {1'b0, a} + {1'b0, b} + {1'b0, c};
      a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
      tick();
      start1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
      n = 1;
      while (!done1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, " latency"}, n, 2);
      check({tag, " result"}, {cout1, sum1}, exp);
      tick();
      check({tag, " done pulse"}, {busy1, done1}, 2'b00);
   endtask

   initial begin
      logic [7:0] pa[4], pb[4];
      logic       pcin[4];
      int         k, ndone, last_t, done_seen;
      logic [8:0] e;

      // 1: reset with start held high
      rst = 1'b1; start8 = 1'b1; start1 = 1'b1; a8 = 8'h55; b8 = 8'h66;
      tick(); tick();
      check("rst busy", busy8, 1'b0);
      check("rst done", done8, 1'b0);
      check("rst sum/cout", {cout8, sum8}, 9'h000);
      check("rst w1", {busy1, done1, cout1, sum1}, 4'b0000);
      rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
      tick();
      check("post rst idle", {busy8, busy1}, 2'b00);

      // 2-4: directed vectors
      op8(8'h00, 8'h00, 1'b0, "zero");
      op8(8'hFF, 8'h01, 1'b0, "ff+01");
      op8(8'h3C, 8'hC3, 1'b0, "3c+c3");
      op8(8'hA5, 8'h5A, 1'b1, "ripple");

      // 5: start held, operands scrambled outside IDLE
      pa[0] = 8'h12; pb[0] = 8'h34; pcin[0] = 1'b1;
      pa[1] = 8'h80; pb[1] = 8'h80; pcin[1] = 1'b0;
      pa[2] = 8'h7F; pb[2] = 8'h01; pcin[2] = 1'b1;
      pa[3] = 8'h00; pb[3] = 8'h00; pcin[3] = 1'b0;
      a8 = pa[0]; b8 = pb[0]; cin8 = pcin[0]; start8 = 1'b1;
      k = 0; ndone = 0; last_t = 0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         if (done8) begin
            e = {1'b0, pa[k]} + {1'b0, pb[k]} + {8'b0, pcin[k]};
            check("held start result", {cout8, sum8}, e);
            if (ndone > 0) check("done spacing", cyc - last_t, 10);
            last_t = cyc; ndone++; k++;
         end
         if (!busy8) begin
            a8 = pa[k]; b8 = pb[k]; cin8 = pcin[k];
         end else begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         end
      end
      start8 = 1'b0;
      check("held start done count", ndone, 3);
      tick();

      // 6: reset in the 4th RUN cycle
      op8(8'h0F, 8'h01, 1'b0, "pre abort");
      a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      check("abort in run", busy8, 1'b1);
      rst = 1'b1;
      tick();
      check("abort state", {busy8, done8}, 2'b00);
      check("abort outputs", {cout8, sum8}, 9'h000);
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8) done_seen++;
      end
      check("no done after abort", done_seen, 0);
      op8(8'h21, 8'h43, 1'b1, "after abort");

      // WIDTH=1 directed and random
      op1(1'b1, 1'b1, 1'b1, "w1 111");
      op1(1'b0, 1'b0, 1'b0, "w1 000");
      op1(1'b1, 1'b0, 1'b0, "w1 100");
      for (int i = 0; i < 1000; i++)
         op1(1'($urandom), 1'($urandom), 1'($urandom), "w1 rnd");

      // WIDTH=8 random sweep
      for (int i = 0; i < 1000; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), "w8 rnd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
